// File: rtl/ipm_mask_serial.sv
// ============================================================================
// Module      : ipm_mask_serial
// Description : Serial inner-product-masking encoder that splits one secret
//               byte into V shares using a single reused GF(2^8) multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gmul8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_sh;

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 on each shift.
    always_comb begin
        o_p  = '0;
        w_sh = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                o_p = o_p ^ w_sh;
            end
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h1B : 8'h00);
        end
    end

endmodule

module ipm_mask_serial #(
    parameter int V = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         secret,
    input  logic [(V-1)*8-1:0] rnd,
    input  logic [V*8-1:0]     L,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [V*8-1:0]     Z,
    output logic               busy
);

    localparam int              c_KW     = $clog2(V);
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(V - 1);
    localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [(V-1)*8-1:0]   r_l;
    logic [(V-1)*8-1:0]   r_z;
    logic [7:0]           r_acc;
    logic [c_KW-1:0]      r_k;
    logic [V*8-1:0]       r_zout;

    logic [7:0]           w_lk;
    logic [7:0]           w_zk;
    logic [7:0]           w_mac;
    logic [7:0]           w_acc_next;

    // L_0 is the constant 0x01, so its byte carries no information.
    logic                 w_unused_l0;
    assign w_unused_l0 = ^L[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_last       = (r_k == c_K_LAST);
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Select the (L_k, Z_k) pair feeding the shared multiplier this cycle.
    always_comb begin
        w_lk = '0;
        w_zk = '0;
        for (int i = 1; i < V; i++) begin
            if (r_k == c_KW'(i)) begin
                w_lk = r_l[(i-1)*8 +: 8];
                w_zk = r_z[(i-1)*8 +: 8];
            end
        end
    end

    gmul8 u_gmul8 (
        .i_a (w_lk),
        .i_b (w_zk),
        .o_p (w_mac)
    );

    assign w_acc_next = r_acc ^ w_mac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l    <= '0;
            r_z    <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_zout <= '0;
        end else if (w_accept) begin
            r_l   <= L[V*8-1:8];
            r_z   <= rnd;
            r_acc <= secret;
            r_k   <= c_K_ONE;
        end else if (r_state == S_COMPUTE) begin
            r_acc <= w_acc_next;
            // The whole share vector updates at once so Z only changes on entry to DONE.
            if (w_last) begin
                r_zout <= {r_z, w_acc_next};
            end else begin
                r_k <= r_k + c_K_ONE;
            end
        end
    end

    assign Z = r_zout;

endmodule

`default_nettype wire
